// File: rtl/sbus_pkg.sv
// sbus_pkg: shared SimpleBus encodings, arbiter FSM state type and the
// read-data pattern returned on a bus error.
package sbus_pkg;

  // Transfer size encodings carried on mst_size / slv_size.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Arbiter FSM: IDLE arbitrates, REQ issues the slave pulse, WAIT holds the bus.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  // Read data returned to the owner when the slave never answers.
  localparam logic [31:0] SBUS_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/sbus_rr_pick.sv
// sbus_rr_pick: combinational N-way picker. mode=0 scans round-robin starting
// after last_grant (with wrap); mode=1 is fixed priority, index 0 highest.
// Outputs are only meaningful when at least one req bit is set.
module sbus_rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  input  logic          mode,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] cand;
  logic          found;

  // Choose the winning requester and produce its index and one-hot grant.
  always_comb begin
    // NOTE: every output and temporary gets a default first so no path leaves it unassigned (no latch).
    gnt_oh  = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    if (mode) begin
      // Walk downwards so the lowest set index is the one left standing.
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) gnt_idx = IW'(i);
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        cand = IW'((int'(last_grant) + k) % N);
        if (!found && req[cand]) begin
          found   = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (|req) gnt_oh[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/sbus_rr_arbiter.sv
// sbus_rr_arbiter: N-master to 1-slave SimpleBus arbiter with one outstanding
// transaction. A winner's request is registered onto slv_*, pulsed for one
// cycle, and the slave response is routed combinationally back to the owner.
// Optional build macro SBUS_ARB_TIMEOUT_EN adds a WAIT-state response timeout
// that answers the owner with an error pulse and SBUS_ERR_DATA.
module sbus_rr_arbiter
  import sbus_pkg::*;
#(
  parameter int N_MST     = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_MST-1:0]           mst_reqValid,
  input  logic [N_MST*AW-1:0]        mst_addr,
  input  logic [N_MST*2-1:0]         mst_size,
  input  logic [N_MST-1:0]           mst_wen,
  input  logic [N_MST*DW-1:0]        mst_wdata,
  input  logic [N_MST*(DW/8)-1:0]    mst_wmask,
  output logic [N_MST-1:0]           mst_respValid,
  output logic [DW-1:0]              mst_rdata,
  output logic [N_MST-1:0]           mst_err,
  output logic                       slv_reqValid,
  output logic [AW-1:0]              slv_addr,
  output logic [1:0]                 slv_size,
  output logic                       slv_wen,
  output logic [DW-1:0]              slv_wdata,
  output logic [DW/8-1:0]            slv_wmask,
  input  logic                       slv_respValid,
  input  logic [DW-1:0]              slv_rdata,
  output logic [$clog2(N_MST)-1:0]   grant_id
);

  localparam int IW = $clog2(N_MST);
  localparam int MW = DW / 8;

  arb_state_e     state_q, state_d;
  logic [IW-1:0]  last_grant_q, last_grant_d;
  logic [IW-1:0]  grant_id_q, grant_id_d;
  logic           slv_req_valid_q, slv_req_valid_d;
  logic [AW-1:0]  slv_addr_q, slv_addr_d;
  logic [1:0]     slv_size_q, slv_size_d;
  logic           slv_wen_q, slv_wen_d;
  logic [DW-1:0]  slv_wdata_q, slv_wdata_d;
  logic [MW-1:0]  slv_wmask_q, slv_wmask_d;

  logic [N_MST-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;

`ifdef SBUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [DW-1:0] err_data;

  // Stretch or cut the 32-bit error pattern to the bus data width.
  always_comb begin
    for (int i = 0; i < DW; i++) err_data[i] = SBUS_ERR_DATA[i % 32];
  end
`endif

  sbus_rr_pick #(
    .N  (N_MST),
    .IW (IW)
  ) u_pick (
    .req        (mst_reqValid),
    .last_grant (last_grant_q),
    .mode       (PRIO_MODE != 0),
    .gnt_oh     (pick_oh),
    .gnt_idx    (pick_idx)
  );

  // Next-state, request capture and combinational response routing.
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    grant_id_d      = grant_id_q;
    slv_req_valid_d = 1'b0;
    slv_addr_d      = slv_addr_q;
    slv_size_d      = slv_size_q;
    slv_wen_d       = slv_wen_q;
    slv_wdata_d     = slv_wdata_q;
    slv_wmask_d     = slv_wmask_q;
    mst_respValid   = '0;
    mst_rdata       = '0;
    mst_err         = '0;
`ifdef SBUS_ARB_TIMEOUT_EN
    wait_cnt_d      = wait_cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // Late or stray slave responses are simply not looked at here.
        if (|pick_oh) begin
          state_d         = ST_REQ;
          last_grant_d    = pick_idx;
          grant_id_d      = pick_idx;
          slv_req_valid_d = 1'b1;
          slv_addr_d      = mst_addr[pick_idx*AW +: AW];
          slv_size_d      = mst_size[pick_idx*2 +: 2];
          slv_wen_d       = mst_wen[pick_idx];
          slv_wdata_d     = mst_wdata[pick_idx*DW +: DW];
          slv_wmask_d     = mst_wmask[pick_idx*MW +: MW];
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
`ifdef SBUS_ARB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        if (slv_respValid) begin
          // A real response wins even in the cycle the timeout would fire.
          mst_respValid[grant_id_q] = 1'b1;
          mst_rdata                 = slv_rdata;
          state_d                   = ST_IDLE;
        end
`ifdef SBUS_ARB_TIMEOUT_EN
        else if (wait_cnt_q == CW'(TIMEOUT)) begin
          mst_respValid[grant_id_q] = 1'b1;
          mst_err[grant_id_q]       = 1'b1;
          mst_rdata                 = err_data;
          state_d                   = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and request registers; reset is synchronous and abandons any transaction.
  always_ff @(posedge clock) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q         <= ST_IDLE;
      last_grant_q    <= IW'(N_MST - 1);
      grant_id_q      <= '0;
      slv_req_valid_q <= 1'b0;
      slv_addr_q      <= '0;
      slv_size_q      <= '0;
      slv_wen_q       <= 1'b0;
      slv_wdata_q     <= '0;
      slv_wmask_q     <= '0;
`ifdef SBUS_ARB_TIMEOUT_EN
      wait_cnt_q      <= '0;
`endif
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      grant_id_q      <= grant_id_d;
      slv_req_valid_q <= slv_req_valid_d;
      slv_addr_q      <= slv_addr_d;
      slv_size_q      <= slv_size_d;
      slv_wen_q       <= slv_wen_d;
      slv_wdata_q     <= slv_wdata_d;
      slv_wmask_q     <= slv_wmask_d;
`ifdef SBUS_ARB_TIMEOUT_EN
      wait_cnt_q      <= wait_cnt_d;
`endif
    end
  end

  assign slv_reqValid = slv_req_valid_q;
  assign slv_addr     = slv_addr_q;
  assign slv_size     = slv_size_q;
  assign slv_wen      = slv_wen_q;
  assign slv_wdata    = slv_wdata_q;
  assign slv_wmask    = slv_wmask_q;
  assign grant_id     = grant_id_q;

endmodule

// File: tb/tb_sbus_rr_arbiter.sv
// tb_sbus_rr_arbiter: two arbiters (round-robin and fixed priority) driven by a
// master/slave model; a transaction-level scoreboard predicts grants, slave
// fields, response routing and read data from the bus rules.
module tb_sbus_rr_arbiter;
  import sbus_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int TO = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // Index 0 = round-robin DUT, index 1 = fixed-priority DUT.
  logic [N-1:0]    req_v    [2];
  logic [N*AW-1:0] addr_v   [2];
  logic [N*2-1:0]  size_v   [2];
  logic [N-1:0]    wen_v    [2];
  logic [N*DW-1:0] wdata_v  [2];
  logic [N*MW-1:0] wmask_v  [2];
  logic [N-1:0]    rv_o     [2];
  logic [DW-1:0]   rd_o     [2];
  logic [N-1:0]    err_o    [2];
  logic            sreq_o   [2];
  logic [AW-1:0]   saddr_o  [2];
  logic [1:0]      ssize_o  [2];
  logic            swen_o   [2];
  logic [DW-1:0]   swdata_o [2];
  logic [MW-1:0]   swmask_o [2];
  logic            sresp_v  [2];
  logic [DW-1:0]   srdata_v [2];
  logic [0:0]      gid_o    [2];

  sbus_rr_arbiter #(.N_MST(N), .AW(AW), .DW(DW), .PRIO_MODE(0), .TIMEOUT(TO)) u_rr (
    .clock(clock), .reset(reset),
    .mst_reqValid(req_v[0]), .mst_addr(addr_v[0]), .mst_size(size_v[0]), .mst_wen(wen_v[0]),
    .mst_wdata(wdata_v[0]), .mst_wmask(wmask_v[0]), .mst_respValid(rv_o[0]), .mst_rdata(rd_o[0]),
    .mst_err(err_o[0]), .slv_reqValid(sreq_o[0]), .slv_addr(saddr_o[0]), .slv_size(ssize_o[0]),
    .slv_wen(swen_o[0]), .slv_wdata(swdata_o[0]), .slv_wmask(swmask_o[0]),
    .slv_respValid(sresp_v[0]), .slv_rdata(srdata_v[0]), .grant_id(gid_o[0]));

  sbus_rr_arbiter #(.N_MST(N), .AW(AW), .DW(DW), .PRIO_MODE(1), .TIMEOUT(TO)) u_pr (
    .clock(clock), .reset(reset),
    .mst_reqValid(req_v[1]), .mst_addr(addr_v[1]), .mst_size(size_v[1]), .mst_wen(wen_v[1]),
    .mst_wdata(wdata_v[1]), .mst_wmask(wmask_v[1]), .mst_respValid(rv_o[1]), .mst_rdata(rd_o[1]),
    .mst_err(err_o[1]), .slv_reqValid(sreq_o[1]), .slv_addr(saddr_o[1]), .slv_size(ssize_o[1]),
    .slv_wen(swen_o[1]), .slv_wdata(swdata_o[1]), .slv_wmask(swmask_o[1]),
    .slv_respValid(sresp_v[1]), .slv_rdata(srdata_v[1]), .grant_id(gid_o[1]));

  int n_checks = 0;
  int n_errors = 0;
  int act = 0;

  // Master model: a pending request with its held fields.
  bit            m_pend  [N];
  logic [AW-1:0] m_addr  [N];
  logic [1:0]    m_size  [N];
  logic          m_wen   [N];
  logic [DW-1:0] m_wdata [N];
  logic [MW-1:0] m_wmask [N];
  bit            reissue [N];
  int            issue_pct = 0;

  // Transaction scoreboard.
  bit busy, waiting, req_due;
  int own, last, gid, wcnt;
  int grants[$];

  // Slave model.
  bit            s_busy, s_rand_lat, stray_en, stray_once, rand_rdata;
  int            s_cnt, s_lat;
  logic [DW-1:0] s_data;

  // Observations for directed checks.
  int            req_pulses;
  logic [N-1:0]  obs_rv, obs_err;
  logic [DW-1:0] obs_rd;
  logic [AW-1:0] cap_addr;
  logic [1:0]    cap_size;
  logic          cap_wen;
  logic [DW-1:0] cap_wdata;
  logic [MW-1:0] cap_wmask;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Winner by the bus rules: lowest index, or first requester after the last owner.
  function automatic int pick(input logic [N-1:0] r, input bit prio, input int last_g);
    int c;
    if (prio) begin
      for (int i = 0; i < N; i++) if (r[i]) return i;
    end else begin
      for (int j = 1; j <= N; j++) begin
        c = (last_g + j) % N;
        if (r[c]) return c;
      end
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [1:0] sz,
                         input logic we, input logic [DW-1:0] wd, input logic [MW-1:0] wm);
    m_pend[i] = 1'b1; m_addr[i] = a; m_size[i] = sz; m_wen[i] = we; m_wdata[i] = wd; m_wmask[i] = wm;
  endtask

  task automatic new_req(input int i);
    set_req(i, $urandom, 2'($urandom_range(0, 2)), 1'($urandom), $urandom, MW'($urandom));
  endtask

  task automatic drive(input bit resp, input logic [DW-1:0] rd);
    for (int d = 0; d < 2; d++) begin
      req_v[d] = '0; addr_v[d] = '0; size_v[d] = '0; wen_v[d] = '0; wdata_v[d] = '0;
      wmask_v[d] = '0; sresp_v[d] = 1'b0; srdata_v[d] = '0;
    end
    for (int i = 0; i < N; i++) begin
      if (m_pend[i]) begin
        req_v[act][i] = 1'b1;
        addr_v[act][i*AW +: AW] = m_addr[i];
        size_v[act][i*2 +: 2] = m_size[i];
        wen_v[act][i] = m_wen[i];
        wdata_v[act][i*DW +: DW] = m_wdata[i];
        wmask_v[act][i*MW +: MW] = m_wmask[i];
      end
    end
    sresp_v[act] = resp;
    srdata_v[act] = rd;
  endtask

  // One clock cycle: drive at negedge, compare just after, then advance the model.
  task automatic step();
    bit            resp, done;
    logic [N-1:0]  rq, e_rv, e_err;
    logic [DW-1:0] e_rd, rdv;
    @(negedge clock);
    resp = 1'b0;
    if (s_busy) begin
      if (s_cnt > 0) begin
        s_cnt--;
        if (s_cnt == 0) begin resp = 1'b1; s_busy = 1'b0; end
      end
    end else if (stray_once || (stray_en && !waiting && $urandom_range(0, 7) == 0)) begin
      resp = 1'b1;
    end
    stray_once = 1'b0;
    rdv = rand_rdata ? DW'($urandom) : s_data;
    for (int i = 0; i < N; i++) rq[i] = m_pend[i];
    drive(resp, rdv);
    #1;
    e_rv = '0; e_err = '0; e_rd = '0;
    if (waiting) begin
      if (resp) begin
        e_rv[own] = 1'b1; e_rd = rdv;
      end
`ifdef SBUS_ARB_TIMEOUT_EN
      else if (wcnt == TO) begin
        e_rv[own] = 1'b1; e_err[own] = 1'b1; e_rd = 32'hDEAD_BEEF;
      end
`endif
    end
    check("slv_reqValid", sreq_o[act], req_due);
    if (req_due) begin
      check("slv_addr", saddr_o[act], m_addr[own]);
      check("slv_size", ssize_o[act], m_size[own]);
      check("slv_wen", swen_o[act], m_wen[own]);
      check("slv_wdata", swdata_o[act], m_wdata[own]);
      check("slv_wmask", swmask_o[act], m_wmask[own]);
    end
    check("mst_respValid", rv_o[act], e_rv);
    check("mst_rdata", rd_o[act], e_rd);
    check("mst_err", err_o[act], e_err);
    check("grant_id", gid_o[act], gid);
    if (sreq_o[act]) begin
      req_pulses++;
      cap_addr = saddr_o[act]; cap_size = ssize_o[act]; cap_wen = swen_o[act];
      cap_wdata = swdata_o[act]; cap_wmask = swmask_o[act];
      s_busy = 1'b1;
      s_cnt = s_rand_lat ? $urandom_range(1, 3) : s_lat;
    end
    if (rv_o[act] != '0) begin obs_rv = rv_o[act]; obs_rd = rd_o[act]; obs_err = err_o[act]; end
    done = (e_rv != '0);
    if (!busy) begin
      if (|rq) begin
        own = pick(rq, act == 1, last); last = own; gid = own;
        busy = 1'b1; req_due = 1'b1; grants.push_back(own);
      end
    end else if (req_due) begin
      req_due = 1'b0; waiting = 1'b1; wcnt = 0;
    end else if (done) begin
      busy = 1'b0; waiting = 1'b0; m_pend[own] = 1'b0;
    end else begin
      wcnt++;
    end
    for (int i = 0; i < N; i++) begin
      if (!m_pend[i] && (reissue[i] || (issue_pct > 0 && $urandom_range(0, 99) < issue_pct)))
        new_req(i);
    end
  endtask

  task automatic do_reset(input int d);
    act = d; issue_pct = 0; stray_en = 1'b0; stray_once = 1'b0;
    for (int i = 0; i < N; i++) begin m_pend[i] = 1'b0; reissue[i] = 1'b0; end
    busy = 1'b0; waiting = 1'b0; req_due = 1'b0; last = N - 1; gid = 0; wcnt = 0;
    s_busy = 1'b0; s_cnt = 0; grants.delete();
    @(negedge clock);
    reset = 1'b0;
    drive(1'b0, '0);
    @(negedge clock);
    #1;
    check("rst_slv_reqValid", sreq_o[d], 1'b0);
    check("rst_slv_addr", saddr_o[d], '0);
    check("rst_slv_size", ssize_o[d], '0);
    check("rst_slv_wen", swen_o[d], 1'b0);
    check("rst_slv_wdata", swdata_o[d], '0);
    check("rst_slv_wmask", swmask_o[d], '0);
    check("rst_respValid", rv_o[d], '0);
    check("rst_err", err_o[d], '0);
    check("rst_grant_id", gid_o[d], '0);
    reset = 1'b1;
  endtask

  task automatic run_grants(input int n, input int budget, input string tag);
    int b = budget;
    while (grants.size() < n && b > 0) begin step(); b--; end
    check({tag, "_grant_bound"}, grants.size() >= n, 1'b1);
  endtask

  task automatic run_resp(input int budget, input string tag);
    int b = budget;
    obs_rv = '0;
    while (obs_rv == '0 && b > 0) begin step(); b--; end
    check({tag, "_resp_bound"}, obs_rv != '0, 1'b1);
  endtask

  task automatic drain(input string tag);
    int b = 100;
    for (int i = 0; i < N; i++) reissue[i] = 1'b0;
    issue_pct = 0; stray_en = 1'b0;
    while ((busy || m_pend[0] || m_pend[1]) && b > 0) begin step(); b--; end
    check({tag, "_drain_bound"}, busy || m_pend[0] || m_pend[1], 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    s_rand_lat = 1'b0; s_lat = 1; rand_rdata = 1'b1; s_data = '0;
    for (int i = 0; i < N; i++) begin m_pend[i] = 1'b0; reissue[i] = 1'b0; end
    drive(1'b0, '0);
    repeat (2) @(negedge clock);

    // Single master 0 word read, 1-cycle slave.
    do_reset(0);
    rand_rdata = 1'b0; s_data = 32'h1234_5678; s_lat = 1; req_pulses = 0;
    set_req(0, 32'h8000_0000, SZ_W, 1'b0, '0, '0);
    run_resp(10, "t1");
    repeat (3) step();
    check("t1_req_pulses", req_pulses, 1);
    check("t1_respValid", obs_rv, 2'b01);
    check("t1_rdata", obs_rd, 32'h1234_5678);
    rand_rdata = 1'b1;

    // Round-robin with both masters requesting continuously.
    do_reset(0);
    s_lat = 2; reissue[0] = 1'b1; reissue[1] = 1'b1; new_req(0); new_req(1);
    run_grants(4, 60, "t2");
    for (int k = 0; k < 4; k++) check($sformatf("t2_grant%0d", k), grants[k], k % 2);
    drain("t2");

    // Fixed priority: master 0 keeps winning until it stops asking.
    do_reset(1);
    s_lat = 1; reissue[0] = 1'b1; reissue[1] = 1'b1; new_req(0); new_req(1);
    run_grants(4, 60, "t3");
    for (int k = 0; k < 4; k++) check($sformatf("t3_grant%0d", k), grants[k], 0);
    reissue[0] = 1'b0;
    begin
      int b = 40;
      while (!(grants.size() > 4 && grants[grants.size() - 1] == 1) && b > 0) begin step(); b--; end
    end
    check("t3_m1_after_m0", grants[grants.size() - 1], 1);
    for (int k = 4; k < grants.size() - 1; k++) check($sformatf("t3_tail%0d", k), grants[k], 0);
    drain("t3");

    // Master 1 byte write: exact slave fields.
    do_reset(0);
    s_lat = 1;
    set_req(1, 32'hA000_03F8, SZ_B, 1'b1, 32'h41, 4'b0001);
    run_resp(10, "t4");
    check("t4_addr", cap_addr, 32'hA000_03F8);
    check("t4_size", cap_size, SZ_B);
    check("t4_wen", cap_wen, 1'b1);
    check("t4_wdata", cap_wdata, 32'h41);
    check("t4_wmask", cap_wmask, 4'b0001);
    check("t4_respValid", obs_rv, 2'b10);

    // Reset in WAIT, stray response afterwards, then fresh arbitration.
    do_reset(0);
    s_lat = 0; new_req(1);
    begin
      int b = 10;
      while (!waiting && b > 0) begin step(); b--; end
    end
    check("t5_in_wait", waiting, 1'b1);
    repeat (3) step();
    do_reset(0);
    obs_rv = '0;
    stray_once = 1'b1;
    repeat (2) step();
    check("t5_no_resp", obs_rv, '0);
    s_lat = 1; new_req(0); new_req(1);
    run_grants(1, 10, "t5");
    check("t5_first_grant", grants[0], 0);
    drain("t5");

`ifdef SBUS_ARB_TIMEOUT_EN
    // Slave never answers: error response after the timeout.
    do_reset(0);
    s_lat = 0; new_req(1);
    run_resp(30, "t6");
    check("t6_respValid", obs_rv, 2'b10);
    check("t6_err", obs_err, 2'b10);
    check("t6_rdata", obs_rd, 32'hDEAD_BEEF);
    s_busy = 1'b0;
    drain("t6");
`endif

    // Random traffic with random latency and stray slave pulses, both DUTs.
    for (int d = 0; d < 2; d++) begin
      do_reset(d);
      s_rand_lat = 1'b1; stray_en = 1'b1; issue_pct = 35;
      repeat (300) step();
      drain($sformatf("rand%0d", d));
      s_rand_lat = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
